// File: rtl/cim_ctrl_pkg.sv
// Shared definitions for the CIM macro array controllers.
//   - cim_wr_state_e : write-sequencer states (idle / setup / write pulse / hold)
//   - CIM_DATA_W     : default weight data word width
//   - CIM_ADDR_W     : default per-bank word address width
package cim_ctrl_pkg;

    localparam int CIM_DATA_W = 24;
    localparam int CIM_ADDR_W = 8;

    typedef enum logic [1:0] {
        CIM_WR_IDLE  = 2'd0,
        CIM_WR_SETUP = 2'd1,
        CIM_WR_WRITE = 2'd2,
        CIM_WR_HOLD  = 2'd3
    } cim_wr_state_e;

endpackage

// File: rtl/cim_bank_write_ctrl.sv
// Sequenced write controller for the CIM weight banks.
// Accepts one write request at a time (valid/ready), registers it, then drives
// the target bank(s) through setup / write-pulse / hold.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : request handshake
//   in_data, in_addr  : word and word address to write
//   in_bank, in_bcast : target bank, or all banks when in_bcast is set
//   D1                : data bus shared by all banks
//   WA                : per-bank address, bank k at [k*ADDR_W +: ADDR_W]
//   WE                : per-bank write enable
//   busy              : a write sequence is in progress
//   err, err_clr      : sticky out-of-range bank flag and its clear
module cim_bank_write_ctrl
    import cim_ctrl_pkg::*;
#(
    parameter int DATA_W    = CIM_DATA_W,
    parameter int ADDR_W    = CIM_ADDR_W,
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = $clog2(NUM_BANKS),  // derived; leave at default
    parameter int WR_CYCLES = 1
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [BANK_W-1:0]           in_bank,
    input  logic                        in_bcast,
    output logic [DATA_W-1:0]           D1,
    output logic [NUM_BANKS*ADDR_W-1:0] WA,
    output logic [NUM_BANKS-1:0]        WE,
    output logic                        busy,
    output logic                        err,
    input  logic                        err_clr
);

    localparam int CNT_W = $clog2(WR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_CYCLES - 1);

    cim_wr_state_e state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]           data_q;
    logic [ADDR_W-1:0]           addr_q;
    logic [NUM_BANKS-1:0]        mask_q;
    logic [NUM_BANKS-1:0]        req_mask;
    logic [NUM_BANKS*ADDR_W-1:0] wa_sel;
    logic                        accept;
    logic                        out_of_range;
    logic                        take;

    assign in_ready = (state_q == CIM_WR_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // A request naming a non-existent bank still completes its handshake,
    // but it is dropped here and only reported through err.
    assign out_of_range = !in_bcast && (32'(in_bank) >= 32'(NUM_BANKS));
    assign take         = accept && !out_of_range;
    assign req_mask     = in_bcast ? {NUM_BANKS{1'b1}}
                                   : (NUM_BANKS'(1) << in_bank);

    // Address fan-out: only banks in the captured mask see the address.
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_wa
        assign wa_sel[k*ADDR_W +: ADDR_W] = mask_q[k] ? addr_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CIM_WR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CIM_WR_IDLE: begin
                if (take) state_d = CIM_WR_SETUP;
            end
            CIM_WR_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = CIM_WR_WRITE;
            end
            CIM_WR_WRITE: begin
                if (cnt_q == '0) state_d = CIM_WR_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            CIM_WR_HOLD: begin
                state_d = CIM_WR_IDLE;
            end
            default: state_d = CIM_WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (take) begin
            data_q <= in_data;
            addr_q <= in_addr;
            mask_q <= req_mask;
        end
    end

    // Bank-side outputs are registered from the current state, so they trail
    // the state register by one cycle: D1/WA settle a cycle before WE rises
    // and remain a cycle after it falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            D1   <= '0;
            WA   <= '0;
            WE   <= '0;
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= (state_d != CIM_WR_IDLE);
            if (accept && out_of_range) err <= 1'b1;  // set beats clear
            else if (err_clr)           err <= 1'b0;
            case (state_q)
                CIM_WR_IDLE: begin
                    WA <= '0;
                    WE <= '0;
                end
                CIM_WR_SETUP: begin
                    D1 <= data_q;
                    WA <= wa_sel;
                    WE <= '0;
                end
                CIM_WR_WRITE: WE <= mask_q;
                CIM_WR_HOLD:  WE <= '0;
                default:      WE <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_bank_write_ctrl.sv
module tb_cim_bank_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] data = '0;
    logic [7:0]  addr = '0;
    logic [1:0]  bank = '0;
    logic        bcast = 1'b0;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A: 2 banks, 1-cycle pulse
    logic        rdy_a, busy_a, err_a;
    logic [23:0] d1_a;
    logic [15:0] wa_a;
    logic [1:0]  we_a;
    cim_bank_write_ctrl #(.NUM_BANKS(2), .WR_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(valid), .in_ready(rdy_a),
        .in_data(data), .in_addr(addr), .in_bank(bank[0:0]), .in_bcast(bcast),
        .D1(d1_a), .WA(wa_a), .WE(we_a), .busy(busy_a), .err(err_a), .err_clr(err_clr));

    // Instance B: 4 banks, 3-cycle pulse
    logic        rdy_b, busy_b, err_b;
    logic [23:0] d1_b;
    logic [31:0] wa_b;
    logic [3:0]  we_b;
    cim_bank_write_ctrl #(.NUM_BANKS(4), .WR_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(valid), .in_ready(rdy_b),
        .in_data(data), .in_addr(addr), .in_bank(bank), .in_bcast(bcast),
        .D1(d1_b), .WA(wa_b), .WE(we_b), .busy(busy_b), .err(err_b), .err_clr(err_clr));

    // Instance C: 3 banks, 2-cycle pulse (bank 3 is out of range)
    logic        rdy_c, busy_c, err_c;
    logic [23:0] d1_c;
    logic [23:0] wa_c;
    logic [2:0]  we_c;
    cim_bank_write_ctrl #(.NUM_BANKS(3), .WR_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(valid), .in_ready(rdy_c),
        .in_data(data), .in_addr(addr), .in_bank(bank), .in_bcast(bcast),
        .D1(d1_c), .WA(wa_c), .WE(we_c), .busy(busy_c), .err(err_c), .err_clr(err_clr));

    // Instance D: 2 banks, 4-cycle pulse
    logic        rdy_d, busy_d, err_d;
    logic [23:0] d1_d;
    logic [15:0] wa_d;
    logic [1:0]  we_d;
    cim_bank_write_ctrl #(.NUM_BANKS(2), .WR_CYCLES(4)) u_d (
        .clk(clk), .rst(rst), .in_valid(valid), .in_ready(rdy_d),
        .in_data(data), .in_addr(addr), .in_bank(bank[0:0]), .in_bcast(bcast),
        .D1(d1_d), .WA(wa_d), .WE(we_d), .busy(busy_d), .err(err_d), .err_clr(err_clr));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0; bcast = 1'b0; err_clr = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d1_a !== 24'h0)   begin errors++; $display("FAIL reset_d1 got %h exp %h", d1_a, 24'h0); end
        checks++; if (wa_b !== 32'h0)   begin errors++; $display("FAIL reset_wa got %h exp %h", wa_b, 32'h0); end
        checks++; if (we_b !== 4'h0)    begin errors++; $display("FAIL reset_we got %h exp %h", we_b, 4'h0); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        checks++; if (err_c !== 1'b0)   begin errors++; $display("FAIL reset_err got %b exp 0", err_c); end
        checks++; if (rdy_a !== 1'b1)   begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_a); end
    endtask

    task automatic test_single();
        do_reset();
        valid = 1'b1; data = 24'hABCDEF; addr = 8'hA5; bank = 2'd0;
        step();  // accept edge
        valid = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy_a); end
        checks++; if (rdy_a !== 1'b0)  begin errors++; $display("FAIL single_ready_busy got %b exp 0", rdy_a); end
        step();  // setup outputs
        checks++; if (d1_a !== 24'hABCDEF) begin errors++; $display("FAIL single_setup_d1 got %h exp %h", d1_a, 24'hABCDEF); end
        checks++; if (wa_a !== 16'h00A5)   begin errors++; $display("FAIL single_setup_wa got %h exp %h", wa_a, 16'h00A5); end
        checks++; if (we_a !== 2'b00)      begin errors++; $display("FAIL single_setup_we got %b exp 00", we_a); end
        step();
        checks++; if (we_a !== 2'b01)      begin errors++; $display("FAIL single_write_we got %b exp 01", we_a); end
        step();
        checks++; if (we_a !== 2'b00)      begin errors++; $display("FAIL single_hold_we got %b exp 00", we_a); end
        checks++; if (wa_a !== 16'h00A5)   begin errors++; $display("FAIL single_hold_wa got %h exp %h", wa_a, 16'h00A5); end
        checks++; if (rdy_a !== 1'b1)      begin errors++; $display("FAIL single_ready got %b exp 1", rdy_a); end
        checks++; if (busy_a !== 1'b0)     begin errors++; $display("FAIL single_busy_fall got %b exp 0", busy_a); end
        step();
        checks++; if (wa_a !== 16'h0000)   begin errors++; $display("FAIL single_idle_wa got %h exp 0000", wa_a); end
        checks++; if (d1_a !== 24'hABCDEF) begin errors++; $display("FAIL single_idle_d1 got %h exp %h", d1_a, 24'hABCDEF); end
    endtask

    task automatic test_multi_cycle();
        logic [3:0] exp_we;
        do_reset();
        valid = 1'b1; data = 24'h123456; addr = 8'h5A; bank = 2'd2;
        step();
        valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_we = (i >= 2 && i <= 4) ? 4'b0100 : 4'b0000;
            checks++; if (we_b !== exp_we) begin errors++; $display("FAIL multi_we cyc %0d got %b exp %b", i, we_b, exp_we); end
            checks++; if (rdy_b !== (i >= 5)) begin errors++; $display("FAIL multi_ready cyc %0d got %b exp %b", i, rdy_b, (i >= 5)); end
            if (i == 2) begin
                checks++; if (wa_b !== 32'h005A0000) begin errors++; $display("FAIL multi_wa got %h exp %h", wa_b, 32'h005A0000); end
                checks++; if (d1_b !== 24'h123456)   begin errors++; $display("FAIL multi_d1 got %h exp %h", d1_b, 24'h123456); end
            end
        end
    endtask

    task automatic test_broadcast();
        logic [7:0]  addrs [2];
        logic [31:0] exp_wa [2];
        logic [3:0]  exp_we;
        addrs[0] = 8'h00; exp_wa[0] = 32'h00000000;
        addrs[1] = 8'h3C; exp_wa[1] = 32'h3C3C3C3C;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            valid = 1'b1; bcast = 1'b1; data = 24'h000000; addr = addrs[v]; bank = 2'd1;
            step();
            valid = 1'b0; bcast = 1'b0;
            for (int i = 1; i <= 5; i++) begin
                step();
                exp_we = (i >= 2 && i <= 4) ? 4'b1111 : 4'b0000;
                checks++; if (we_b !== exp_we) begin errors++; $display("FAIL bcast_we v%0d cyc %0d got %b exp %b", v, i, we_b, exp_we); end
                if (i == 3) begin
                    checks++; if (wa_b !== exp_wa[v]) begin errors++; $display("FAIL bcast_wa v%0d got %h exp %h", v, wa_b, exp_wa[v]); end
                end
            end
        end
    endtask

    task automatic test_bad_bank();
        do_reset();
        valid = 1'b1; data = 24'h111111; addr = 8'h11; bank = 2'd3;
        checks++; if (rdy_c !== 1'b1) begin errors++; $display("FAIL err_handshake_ready got %b exp 1", rdy_c); end
        step();
        valid = 1'b0;
        checks++; if (err_c !== 1'b1)  begin errors++; $display("FAIL err_set got %b exp 1", err_c); end
        checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL err_busy got %b exp 0", busy_c); end
        checks++; if (rdy_c !== 1'b1)  begin errors++; $display("FAIL err_stay_idle got %b exp 1", rdy_c); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (we_c !== 3'b000) begin errors++; $display("FAIL err_no_we cyc %0d got %b exp 000", i, we_c); end
            checks++; if (err_c !== 1'b1)  begin errors++; $display("FAIL err_sticky cyc %0d got %b exp 1", i, err_c); end
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_c); end
        // clear and a new error together: set wins
        valid = 1'b1; err_clr = 1'b1; bank = 2'd3;
        step();
        valid = 1'b0; err_clr = 1'b0;
        checks++; if (err_c !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", err_c); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        valid = 1'b1; data = 24'hC0FFEE; addr = 8'h77; bank = 2'd1;
        step();
        valid = 1'b0;
        step();
        step();
        checks++; if (we_d !== 2'b10)      begin errors++; $display("FAIL rmid_we_before got %b exp 10", we_d); end
        checks++; if (d1_d !== 24'hC0FFEE) begin errors++; $display("FAIL rmid_d1_before got %h exp %h", d1_d, 24'hC0FFEE); end
        checks++; if (wa_d !== 16'h7700)   begin errors++; $display("FAIL rmid_wa_before got %h exp %h", wa_d, 16'h7700); end
        step();
        rst = 1'b1;
        step();
        checks++; if (we_d !== 2'b00)  begin errors++; $display("FAIL rmid_we got %b exp 00", we_d); end
        checks++; if (wa_d !== 16'h0)  begin errors++; $display("FAIL rmid_wa got %h exp 0000", wa_d); end
        checks++; if (d1_d !== 24'h0)  begin errors++; $display("FAIL rmid_d1 got %h exp 000000", d1_d); end
        checks++; if (busy_d !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy_d); end
        checks++; if (rdy_d !== 1'b0)  begin errors++; $display("FAIL rmid_ready_in_rst got %b exp 0", rdy_d); end
        rst = 1'b0;
        #1;
        checks++; if (rdy_d !== 1'b1)  begin errors++; $display("FAIL rmid_ready got %b exp 1", rdy_d); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (we_d !== 2'b00) begin errors++; $display("FAIL rmid_we_after cyc %0d got %b exp 00", i, we_d); end
        end
    endtask

    task automatic test_back_to_back();
        // WR_CYCLES=4: accepts land on edges 0, 7, 14; each pulses WE on
        // edges a+2..a+5 with the word that was on the bus at edge a.
        int          a;
        logic [1:0]  exp_we;
        do_reset();
        valid = 1'b1; bank = 2'd0;
        for (int k = 0; k <= 20; k++) begin
            data = 24'hA00000 + 24'(k);
            addr = 8'(k);
            step();
            a = (k / 7) * 7;
            exp_we = ((k - a) >= 2 && (k - a) <= 5) ? 2'b01 : 2'b00;
            checks++; if (we_d !== exp_we) begin errors++; $display("FAIL b2b_we edge %0d got %b exp %b", k, we_d, exp_we); end
            if (exp_we != 2'b00) begin
                checks++; if (d1_d !== 24'hA00000 + 24'(a)) begin errors++; $display("FAIL b2b_d1 edge %0d got %h exp %h", k, d1_d, 24'hA00000 + 24'(a)); end
                checks++; if (wa_d !== {8'h00, 8'(a)}) begin errors++; $display("FAIL b2b_wa edge %0d got %h exp %h", k, wa_d, {8'h00, 8'(a)}); end
            end
        end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_cycle();
        test_broadcast();
        test_bad_bank();
        test_reset_mid_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
